// File: rtl/sar_compare_search.sv
// sar_compare_search: successive-approximation search that recovers a comparator's unknown A operand via probe/R
module sar_compare_search #(
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [2:0]                 R,
  output logic [WIDTH-1:0]           probe,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH-1:0]           result,
  output logic [$clog2(WIDTH+1)-1:0] nprobe,
  output logic                       err
);
  localparam int NW = $clog2(WIDTH + 1);
  localparam int KW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;
  state_t state, state_n;
  logic [KW-1:0] k;
  logic [WIDTH-1:0] bitk, upd;
  logic is_lt, is_gt, is_eq, ok;
  always_comb begin
    is_lt = R == 3'b001;
    is_gt = R == 3'b100;
    is_eq = R == 3'b010;
    ok = is_lt | is_gt;
    bitk = WIDTH'(1) << k;
    upd = is_lt ? probe & ~bitk : probe;
    state_n = state == IDLE  ? (start ? PROBE : IDLE) :
              state == PROBE ? ((!ok || k == '0) ? DONE : PROBE) : IDLE;
    busy = state == PROBE;
    done = state == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      probe <= '0;
      result <= '0;
      nprobe <= '0;
      err <= 1'b0;
      k <= '0;
    end else if (state == IDLE) begin
      probe <= start ? WIDTH'(1) << (WIDTH - 1) : '0;
      if (start) begin
        k <= KW'(WIDTH - 1);
        nprobe <= '0;
        err <= 1'b0;
      end
    end else if (state == PROBE) begin
      nprobe <= nprobe + NW'(1);
      // non-lt/gt ends the search: equality is an early hit, anything else is a bad comparator code
      if (!ok) begin
        result <= probe;
        err <= !is_eq;
      end else if (k == '0) begin
        result <= upd;
      end else begin
        probe <= upd | (bitk >> 1);
        k <= k - KW'(1);
      end
    end else begin
      probe <= '0;
    end
  end
endmodule
